pin_mux: RTL and testbench

PIN_MUX -- requirements
Module: pin_mux

---
 rtl/pin_mux.sv | 122 ++++++++++++
 tb/tb_pin_mux.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pin_mux.sv
// pin_mux: bus-programmed pad function multiplexer with safe-state switching gaps.
// Define PIN_MUX_FILTER_EN to add a per-pin input stability filter after the synchroniser.
module pin_mux #(
  parameter logic [31:0] MUX_BASE_ADDR = 32'h40006000,
  parameter int PIN_NUM = 8,
  parameter int FUNC_NUM = 4,
  parameter int GAP_CYCLES = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 mem_addr,
  input  logic [31:0]                 mem_wdata,
  input  logic                        mem_we,
  input  logic                        mem_re,
  output logic [31:0]                 mem_rdata,
  input  logic [PIN_NUM*FUNC_NUM-1:0] func_out,
  input  logic [PIN_NUM*FUNC_NUM-1:0] func_oe,
  output logic [PIN_NUM-1:0]          pad_out,
  output logic [PIN_NUM-1:0]          pad_oe,
  input  logic [PIN_NUM-1:0]          pad_in,
  output logic [PIN_NUM-1:0]          func_in
);
  localparam int SEL_W = $clog2(FUNC_NUM);
  localparam logic [0:0] ACTIVE = 1'b0;
  localparam logic [0:0] GAP = 1'b1;
  logic hit, wr_ok, lock_wr, lock_q;
  logic [7:0] off;
  logic [31:0] rdata_d, rdata_q;
  logic [SEL_W-1:0] sel_q [PIN_NUM];
  logic [3:0] cnt_q [PIN_NUM];
  logic [PIN_NUM-1:0] st_q, sel_wr, sel_o, sel_e, pad_out_q, pad_oe_q, sync1_q, sync2_q;
  assign hit = mem_addr[31:8] == MUX_BASE_ADDR[31:8];
  assign off = mem_addr[7:0];
  assign wr_ok = hit && mem_we && !lock_q && mem_wdata < 32'(FUNC_NUM);
  assign lock_wr = hit && mem_we && off == 8'h80 && mem_wdata[0];
  assign mem_rdata = rdata_q;
  assign pad_out = pad_out_q;
  assign pad_oe = pad_oe_q;
  for (genvar k = 0; k < PIN_NUM; k++) begin : g_pin
    logic [FUNC_NUM-1:0] fo, fe;
    assign fo = func_out[k*FUNC_NUM +: FUNC_NUM];
    assign fe = func_oe[k*FUNC_NUM +: FUNC_NUM];
    assign sel_o[k] = fo[sel_q[k]];
    assign sel_e[k] = fe[sel_q[k]];
    // a rewrite during a gap always restarts it, even with an unchanged value
    assign sel_wr[k] = wr_ok && off == 8'(4*k) &&
                       (mem_wdata[SEL_W-1:0] != sel_q[k] || st_q[k] == GAP);
  end
  always_comb begin
    rdata_d = '0;
    if (hit && mem_re) begin
      if (off == 8'h80) rdata_d[0] = lock_q;
      if (off == 8'h84) rdata_d[PIN_NUM-1:0] = func_in;
      for (int i = 0; i < PIN_NUM; i++)
        if (off == 8'(4*i)) rdata_d[SEL_W-1:0] = sel_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
      rdata_q <= '0;
      st_q <= '0;
      pad_out_q <= '0;
      pad_oe_q <= '0;
      for (int i = 0; i < PIN_NUM; i++) begin
        sel_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      lock_q <= lock_q | lock_wr;
      rdata_q <= rdata_d;
      for (int i = 0; i < PIN_NUM; i++) begin
        if (sel_wr[i]) begin
          sel_q[i] <= mem_wdata[SEL_W-1:0];
          st_q[i] <= GAP;
          cnt_q[i] <= 4'(GAP_CYCLES);
          pad_out_q[i] <= 1'b0;
          pad_oe_q[i] <= 1'b0;
        end else if (st_q[i] == GAP) begin
          cnt_q[i] <= cnt_q[i] - 4'd1;
          st_q[i] <= (cnt_q[i] == 4'd1) ? ACTIVE : GAP;
          pad_out_q[i] <= (cnt_q[i] == 4'd1) & sel_o[i];
          pad_oe_q[i] <= (cnt_q[i] == 4'd1) & sel_e[i];
        end else begin
          pad_out_q[i] <= sel_o[i];
          pad_oe_q[i] <= sel_e[i];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
    end
  end
`ifdef PIN_MUX_FILTER_EN
  logic [7:0] fcnt_q [PIN_NUM];
  logic [PIN_NUM-1:0] fin_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      fin_q <= '0;
      for (int i = 0; i < PIN_NUM; i++) fcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < PIN_NUM; i++) begin
        if (sync2_q[i] == fin_q[i]) fcnt_q[i] <= '0;
        else if (fcnt_q[i] == 8'(FILTER_CYCLES-1)) begin
          fin_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else fcnt_q[i] <= fcnt_q[i] + 8'd1;
      end
    end
  end
  assign func_in = fin_q;
`else
  assign func_in = sync2_q;
`endif
endmodule

// File: tb/tb_pin_mux.sv
// tb_pin_mux: self-checking bench for pin_mux; register reads go through a scoreboard queue.
module tb_pin_mux;
  localparam int P = 8;
  localparam int F = 4;
  localparam logic [31:0] BASE = 32'h40006000;
  typedef struct {logic [31:0] v; string n;} exp_t;
  logic clk = 0, rst = 1;
  logic [31:0] mem_addr = 0, mem_wdata = 0, mem_rdata;
  logic mem_we = 0, mem_re = 0, pend = 0;
  logic [P*F-1:0] func_out = 0, func_oe = 0;
  logic [P-1:0] pad_out, pad_oe, pad_in = 0, func_in;
  int tests = 0, fails = 0;
  exp_t sb[$];
  exp_t e_m;
  pin_mux #(.MUX_BASE_ADDR(BASE), .PIN_NUM(P), .FUNC_NUM(F), .GAP_CYCLES(2), .FILTER_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .func_out(func_out), .func_oe(func_oe),
    .pad_out(pad_out), .pad_oe(pad_oe), .pad_in(pad_in), .func_in(func_in)
  );
  always #5 clk = ~clk;
  always @(posedge clk) pend <= mem_re;
  // read data is due one cycle after each read strobe and must be 0 otherwise
  always @(negedge clk) begin
    tests++;
    if (pend) begin
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rdata_unexpected: got %h, no read outstanding", mem_rdata);
      end else begin
        e_m = sb.pop_front();
        if (mem_rdata !== e_m.v) begin
          fails++;
          $display("FAIL %s: got %h, expected %h", e_m.n, mem_rdata, e_m.v);
        end
      end
    end else if (mem_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rdata_idle: got %h, expected 0", mem_rdata);
    end
  end
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr = a; mem_wdata = d; mem_we = 1;
    @(negedge clk); mem_we = 0;
  endtask
  task automatic bus_rd(input logic [31:0] a, input logic [31:0] v, input string n);
    mem_addr = a; mem_re = 1; sb.push_back('{v, n});
    @(negedge clk); mem_re = 0;
  endtask
  task automatic test_reset;
    for (int k = 0; k < P; k++) begin func_out[k*F] = 1; func_oe[k*F] = 1; end
    repeat (2) @(negedge clk);
    tests++; if (pad_out !== 0 || pad_oe !== 0) begin fails++; $display("FAIL reset_pad: out=%h oe=%h, expected 00", pad_out, pad_oe); end
    tests++; if (func_in !== 0) begin fails++; $display("FAIL reset_func_in: got %h, expected 00", func_in); end
    rst = 0;
    @(negedge clk);
    tests++; if (pad_out !== 8'hFF || pad_oe !== 8'hFF) begin fails++; $display("FAIL reset_func0: out=%h oe=%h, expected ff", pad_out, pad_oe); end
    bus_rd(BASE, 0, "sel0_reset");
    bus_rd(BASE + 32'h80, 0, "lock_reset");
  endtask
  task automatic test_gap;
    func_out[3*F+2] = 1; func_oe[3*F+2] = 1;
    bus_wr(BASE + 32'h0C, 2);
    tests++; if (pad_oe !== 8'hF7 || pad_out[3] !== 0) begin fails++; $display("FAIL gap_c1: oe=%h out3=%b, expected f7/0", pad_oe, pad_out[3]); end
    @(negedge clk);
    tests++; if (pad_oe[3] !== 0 || pad_out[3] !== 0) begin fails++; $display("FAIL gap_c2: oe3=%b out3=%b, expected 0/0", pad_oe[3], pad_out[3]); end
    @(negedge clk);
    tests++; if (pad_oe[3] !== 1 || pad_out[3] !== 1) begin fails++; $display("FAIL gap_end: oe3=%b out3=%b, expected 1/1", pad_oe[3], pad_out[3]); end
    bus_rd(BASE + 32'h0C, 2, "sel3_readback");
    bus_wr(BASE + 32'h0C, 2);
    tests++; if (pad_oe[3] !== 1) begin fails++; $display("FAIL same_sel_no_gap: oe3=%b, expected 1", pad_oe[3]); end
    func_out[3*F+2] = 0;
    @(negedge clk);
    tests++; if (pad_out[3] !== 0) begin fails++; $display("FAIL follow_latency: out3=%b, expected 0", pad_out[3]); end
  endtask
  task automatic test_invalid;
    bus_wr(BASE + 32'h04, 5);
    tests++; if (pad_oe[1] !== 1) begin fails++; $display("FAIL invalid5_gap: oe1=%b, expected 1", pad_oe[1]); end
    bus_wr(BASE + 32'h04, F);
    tests++; if (pad_oe[1] !== 1) begin fails++; $display("FAIL invalid4_gap: oe1=%b, expected 1", pad_oe[1]); end
    bus_rd(BASE + 32'h04, 0, "sel1_invalid");
    bus_wr(BASE + 32'h04, F - 1);
    tests++; if (pad_oe[1] !== 0) begin fails++; $display("FAIL max_sel_gap: oe1=%b, expected 0", pad_oe[1]); end
    repeat (2) @(negedge clk);
    bus_rd(BASE + 32'h04, F - 1, "sel1_max");
  endtask
  task automatic test_back_to_back;
    func_out[2*F+3] = 1; func_oe[2*F+3] = 1; func_oe[2*F+1] = 1;
    bus_wr(BASE + 32'h08, 1);
    bus_wr(BASE + 32'h08, 3);
    tests++; if (pad_oe[2] !== 0) begin fails++; $display("FAIL b2b_c2: oe2=%b, expected 0", pad_oe[2]); end
    @(negedge clk);
    tests++; if (pad_oe[2] !== 0) begin fails++; $display("FAIL b2b_c3: oe2=%b, expected 0", pad_oe[2]); end
    @(negedge clk);
    tests++; if (pad_oe[2] !== 1 || pad_out[2] !== 1) begin fails++; $display("FAIL b2b_end: oe2=%b out2=%b, expected 1/1", pad_oe[2], pad_out[2]); end
    bus_rd(BASE + 32'h08, 3, "sel2_b2b");
  endtask
  task automatic test_lock;
    bus_wr(BASE + 32'h80, 1);
    bus_wr(BASE, 1);
    tests++; if (pad_oe[0] !== 1) begin fails++; $display("FAIL locked_no_gap: oe0=%b, expected 1", pad_oe[0]); end
    bus_rd(BASE, 0, "sel0_locked");
    bus_rd(BASE + 32'h80, 1, "lock_set");
    rst = 1;
    @(negedge clk);
    rst = 0;
    bus_rd(BASE + 32'h80, 0, "lock_cleared");
    bus_rd(BASE + 32'h0C, 0, "sel3_cleared");
  endtask
  task automatic test_reset_gap;
    bus_wr(BASE + 32'h10, 1);
    tests++; if (pad_oe[4] !== 0) begin fails++; $display("FAIL rgap_enter: oe4=%b, expected 0", pad_oe[4]); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    tests++; if (pad_oe[4] !== 1 || pad_out[4] !== 1) begin fails++; $display("FAIL rgap_abort: oe4=%b out4=%b, expected 1/1", pad_oe[4], pad_out[4]); end
  endtask
  task automatic test_map;
    bus_wr(BASE, 2);
    bus_wr(32'h40007004, 1);
    bus_wr(BASE + 32'h40, 1);
    repeat (2) @(negedge clk);
    bus_rd(BASE, 2, "sel0_written");
    bus_rd(32'h40007000, 0, "addr_miss");
    bus_rd(BASE + 32'h04, 0, "sel1_miss_write");
    bus_rd(BASE + 32'h40, 0, "unmapped_40");
    bus_rd(BASE + 32'h88, 0, "unmapped_88");
  endtask
`ifdef PIN_MUX_FILTER_EN
  task automatic test_filter;
    logic bad;
    bad = 0;
    pad_in[0] = 1;
    repeat (3) @(negedge clk);
    pad_in[0] = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (func_in[0] !== 0) bad = 1;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL filter_short: func_in0 rose, expected 0"); end
    pad_in[0] = 1;
    repeat (5) @(negedge clk);
    tests++; if (func_in[0] !== 0) begin fails++; $display("FAIL filter_early: got %b at cycle 5, expected 0", func_in[0]); end
    @(negedge clk);
    tests++; if (func_in[0] !== 1) begin fails++; $display("FAIL filter_rise: got %b at cycle 6, expected 1", func_in[0]); end
    repeat (4) @(negedge clk);
    pad_in[0] = 0;
    repeat (8) @(negedge clk);
  endtask
`else
  task automatic test_sync;
    pad_in[5] = 1;
    @(negedge clk);
    tests++; if (func_in[5] !== 0) begin fails++; $display("FAIL sync_early: got %b, expected 0", func_in[5]); end
    @(negedge clk);
    tests++; if (func_in[5] !== 1) begin fails++; $display("FAIL sync_rise: got %b, expected 1", func_in[5]); end
    bus_rd(BASE + 32'h84, 32'h20, "pin_in");
    pad_in[5] = 0;
    repeat (3) @(negedge clk);
  endtask
`endif
  initial begin
    test_reset;
    test_gap;
    test_invalid;
    test_back_to_back;
    test_lock;
    test_reset_gap;
    test_map;
`ifdef PIN_MUX_FILTER_EN
    test_filter;
`else
    test_sync;
`endif
    @(negedge clk);
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL sb_drain: %0d reads outstanding, expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
